trace_reg_monitor: RTL and testbench

Multi-core register-writeback monitor for the debug-enabled system testbenches. It generalises the single-register, single-core r3 checker in three ways: N cores, a configurable watch register for the shadow outputs, and a mask of registers whose writes become events. Per core, it keeps a shadow of the watched register and queues watched writes in a small FIFO. A round-robin arbiter drains all queues into one valid/ready event stream for the C++ harness. Per-core overflow is flagged and counted.

---
 rtl/trace_reg_monitor_pkg.sv | 13 +
 rtl/trace_reg_monitor_if.sv | 17 +
 rtl/trace_reg_monitor_fifo.sv | 64 ++++++
 rtl/trace_reg_monitor.sv | 181 ++++++++++++++++++
 tb/tb_trace_reg_monitor.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_reg_monitor_pkg.sv
// Shared types for the register-writeback trace monitor: the queued event
// record and the trace field widths.
package trace_monitor_pkg;

  localparam int TRACE_REG_W  = 5;
  localparam int TRACE_DATA_W = 32;

  typedef struct packed {
    logic [TRACE_REG_W-1:0]  regno;
    logic [TRACE_DATA_W-1:0] data;
  } trace_event_t;

endpackage

// File: rtl/trace_reg_monitor_if.sv
// Merged event stream from the monitor to the harness (valid/ready handshake).
interface trace_reg_monitor_if #(
  parameter int CORE_W = 2
);
  import trace_monitor_pkg::*;

  logic                    ev_valid;
  logic                    ev_ready;
  logic [CORE_W-1:0]       ev_core;
  logic [TRACE_REG_W-1:0]  ev_reg;
  logic [TRACE_DATA_W-1:0] ev_data;

  modport master (output ev_valid, output ev_core, output ev_reg, output ev_data,
                  input  ev_ready);
  modport slave  (input  ev_valid, input  ev_core, input  ev_reg, input  ev_data,
                  output ev_ready);
endinterface

// File: rtl/trace_reg_monitor_fifo.sv
// Per-core event queue; exposes the head and the entry behind it so the
// arbiter can pick the next event in the same cycle it pops the current one.
module trace_event_fifo
  import trace_monitor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  trace_event_t             din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output trace_event_t             head_o,
  output trace_event_t             head_nxt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  trace_event_t  mem_q [DEPTH];

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop on a full queue frees the slot the simultaneous push lands in.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign rd_nxt     = rd_ptr_q + PW'(1);
  assign head_o     = mem_q[rd_ptr_q];
  assign head_nxt_o = mem_q[rd_nxt];

endmodule

// File: rtl/trace_reg_monitor.sv
// Multi-core writeback monitor: per-core shadow of one register, per-core event
// queues merged round-robin into one registered event stream, overflow tracking.
module trace_reg_monitor
  import trace_monitor_pkg::*;
#(
  parameter int          NUMCORES   = 4,
  parameter int          WATCH_REG  = 3,
  parameter logic [31:0] EVENT_MASK = 32'h0000_0008,
  parameter int          FIFO_DEPTH = 4,
  parameter bit          IGNORE_R0  = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_sys_n,
  input  logic [NUMCORES-1:0]                tr_valid,
  input  logic [NUMCORES-1:0]                tr_we,
  input  logic [TRACE_REG_W*NUMCORES-1:0]    tr_addr,
  input  logic [TRACE_DATA_W*NUMCORES-1:0]   tr_data,
  output logic [TRACE_DATA_W*NUMCORES-1:0]   shadow,
  trace_reg_monitor_if.master                ev,
  output logic [NUMCORES-1:0]                ovf,
  output logic [15:0]                        drop_cnt,
  input  logic                               ovf_clr
);

  localparam int CORE_W = (NUMCORES > 1) ? $clog2(NUMCORES) : 1;
  localparam int PC_W   = CORE_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TRACE_REG_W-1:0] WATCH_IDX = TRACE_REG_W'(WATCH_REG);

  function automatic logic [PC_W-1:0] popcount(input logic [NUMCORES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < NUMCORES; k++) c = c + PC_W'(v[k]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] base, input logic [PC_W-1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [CORE_W-1:0] next_core(input logic [CORE_W-1:0] c);
    return (c == CORE_W'(NUMCORES - 1)) ? '0 : c + CORE_W'(1);
  endfunction

  logic [TRACE_REG_W-1:0]  addr     [NUMCORES];
  trace_event_t            wr_ev    [NUMCORES];
  trace_event_t            head     [NUMCORES];
  trace_event_t            head_nxt [NUMCORES];
  trace_event_t            look_ev  [NUMCORES];
  logic                    look_vld [NUMCORES];
  logic [CNT_W-1:0]        cnt      [NUMCORES];
  logic [TRACE_DATA_W-1:0] shadow_q [NUMCORES];
  logic [TRACE_DATA_W-1:0] shadow_d [NUMCORES];
  logic [NUMCORES-1:0]     qual, push, pop, full, empty, drop;

  logic                ev_valid_q, ev_valid_d;
  logic [CORE_W-1:0]   ev_core_q, ev_core_d;
  trace_event_t        ev_q, ev_d;
  logic [CORE_W-1:0]   ptr_q, ptr_d;
  logic [CORE_W-1:0]   start, grant_idx;
  logic                grant_found, hs, load;
  logic [NUMCORES-1:0] ovf_q, ovf_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  assign hs   = ev_valid_q & ev.ev_ready;
  assign load = ~ev_valid_q | ev.ev_ready;

  for (genvar gi = 0; gi < NUMCORES; gi++) begin : g_core
    assign addr[gi]  = tr_addr[TRACE_REG_W*gi +: TRACE_REG_W];
    assign wr_ev[gi] = '{regno: addr[gi], data: tr_data[TRACE_DATA_W*gi +: TRACE_DATA_W]};
    assign qual[gi]  = tr_valid[gi] & tr_we[gi] & ~(IGNORE_R0 && (addr[gi] == '0));
    assign push[gi]  = qual[gi] & EVENT_MASK[addr[gi]];
    assign pop[gi]   = hs & (ev_core_q == CORE_W'(gi));
    assign drop[gi]  = push[gi] & full[gi] & ~pop[gi];
    assign shadow[TRACE_DATA_W*gi +: TRACE_DATA_W] = shadow_q[gi];

    trace_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_sys_n),
      .push_i     (push[gi]),
      .din_i      (wr_ev[gi]),
      .pop_i      (pop[gi]),
      .full_o     (full[gi]),
      .empty_o    (empty[gi]),
      .count_o    (cnt[gi]),
      .head_o     (head[gi]),
      .head_nxt_o (head_nxt[gi])
    );
  end

  // Head each queue will present after this cycle's pop/push; an empty queue
  // falls through to the incoming write so the event appears one cycle later.
  always_comb begin
    for (int i = 0; i < NUMCORES; i++) begin
      look_vld[i] = 1'b0;
      look_ev[i]  = head[i];
      shadow_d[i] = shadow_q[i];
      if (qual[i] && (addr[i] == WATCH_IDX)) shadow_d[i] = wr_ev[i].data;
      if (pop[i]) begin
        if (cnt[i] >= CNT_W'(2)) begin
          look_vld[i] = 1'b1;
          look_ev[i]  = head_nxt[i];
        end else if (push[i]) begin
          look_vld[i] = 1'b1;
          look_ev[i]  = wr_ev[i];
        end
      end else if (!empty[i]) begin
        look_vld[i] = 1'b1;
      end else if (push[i]) begin
        look_vld[i] = 1'b1;
        look_ev[i]  = wr_ev[i];
      end
    end
  end

  always_comb begin
    start       = hs ? next_core(ev_core_q) : ptr_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUMCORES; k++) begin
      int c;
      c = (int'(start) + k) % NUMCORES;
      if (!grant_found && look_vld[c]) begin
        grant_found = 1'b1;
        grant_idx   = CORE_W'(c);
      end
    end
  end

  // Output stage mirrors the head of the granted queue; the entry leaves the
  // queue only on handshake, so a stalled stream keeps grant and fields fixed.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_core_d  = ev_core_q;
    ev_d       = ev_q;
    ptr_d      = ptr_q;
    if (hs) ptr_d = next_core(ev_core_q);
    if (load) begin
      ev_valid_d = grant_found;
      if (grant_found) begin
        ev_core_d = grant_idx;
        ev_d      = look_ev[grant_idx];
      end
    end
  end

  always_comb begin
    ovf_d      = (ovf_clr ? '0 : ovf_q) | drop;
    drop_cnt_d = sat_add(ovf_clr ? 16'h0 : drop_cnt_q, popcount(drop));
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      ev_valid_q <= 1'b0;
      ev_core_q  <= '0;
      ev_q       <= '0;
      ptr_q      <= '0;
      ovf_q      <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < NUMCORES; i++) shadow_q[i] <= '0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_core_q  <= ev_core_d;
      ev_q       <= ev_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < NUMCORES; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_core  = ev_core_q;
  assign ev.ev_reg   = ev_q.regno;
  assign ev.ev_data  = ev_q.data;
  assign ovf         = ovf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_trace_reg_monitor.sv
// Directed bench for trace_reg_monitor: default configuration plus a second
// instance whose event mask selects r5 only.
module tb_trace_reg_monitor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   tr_valid, tr_we;
  logic [19:0]  tr_addr;
  logic [127:0] tr_data;
  logic [127:0] shadow, shadow5;
  logic [3:0]   ovf, ovf5;
  logic [15:0]  drop_cnt, drop5;
  logic         ovf_clr;
  logic         ev_ready, ev5_ready;
  int           total = 0;
  int           bad   = 0;
  logic [1:0]   ec [7];
  logic [31:0]  ed [7];

  trace_reg_monitor_if #(.CORE_W(2)) ev_if ();
  trace_reg_monitor_if #(.CORE_W(2)) ev5_if ();

  assign ev_if.ev_ready  = ev_ready;
  assign ev5_if.ev_ready = ev5_ready;

  trace_reg_monitor #(
    .NUMCORES(4), .WATCH_REG(3), .EVENT_MASK(32'h0000_0008), .FIFO_DEPTH(4), .IGNORE_R0(1'b1)
  ) u_dut (
    .clk(clk), .rst_sys_n(rst_n), .tr_valid(tr_valid), .tr_we(tr_we), .tr_addr(tr_addr),
    .tr_data(tr_data), .shadow(shadow), .ev(ev_if), .ovf(ovf), .drop_cnt(drop_cnt),
    .ovf_clr(ovf_clr)
  );

  trace_reg_monitor #(
    .NUMCORES(4), .WATCH_REG(3), .EVENT_MASK(32'h0000_0020), .FIFO_DEPTH(4), .IGNORE_R0(1'b1)
  ) u_dut5 (
    .clk(clk), .rst_sys_n(rst_n), .tr_valid(tr_valid), .tr_we(tr_we), .tr_addr(tr_addr),
    .tr_data(tr_data), .shadow(shadow5), .ev(ev5_if), .ovf(ovf5), .drop_cnt(drop5),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic [1:0] c, input logic [4:0] r,
                        input logic [31:0] d);
    chk({tag, ".valid"}, 64'(ev_if.ev_valid), 64'd1);
    chk({tag, ".core"},  64'(ev_if.ev_core),  64'(c));
    chk({tag, ".reg"},   64'(ev_if.ev_reg),   64'(r));
    chk({tag, ".data"},  64'(ev_if.ev_data),  64'(d));
  endtask

  task automatic set_wr(input int c, input logic [4:0] a, input logic [31:0] d,
                        input logic we);
    tr_valid[c]          = 1'b1;
    tr_we[c]             = we;
    tr_addr[5*c +: 5]    = a;
    tr_data[32*c +: 32]  = d;
  endtask

  task automatic clr_tr();
    tr_valid = '0;
    tr_we    = '0;
    tr_addr  = '0;
    tr_data  = '0;
  endtask

  initial begin
    rst_n = 1'b0; ev_ready = 1'b0; ev5_ready = 1'b1; ovf_clr = 1'b0;
    clr_tr();
    tick(); tick(); tick();
    chk("rst.shadow_lo", shadow[63:0], 64'h0);
    chk("rst.shadow_hi", shadow[127:64], 64'h0);
    chk("rst.valid", 64'(ev_if.ev_valid), 64'd0);
    chk("rst.core", 64'(ev_if.ev_core), 64'd0);
    chk("rst.reg", 64'(ev_if.ev_reg), 64'd0);
    chk("rst.data", 64'(ev_if.ev_data), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    chk("rst.drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.valid", 64'(ev_if.ev_valid), 64'd0);

    // single write from core 2
    set_wr(2, 5'd3, 32'hDEAD_BEEF, 1'b1);
    tick(); clr_tr();
    chk("c2.shadow2", 64'(shadow[95:64]), 64'hDEAD_BEEF);
    chk("c2.shadow0", 64'(shadow[31:0]), 64'h0);
    chk("c2.shadow1", 64'(shadow[63:32]), 64'h0);
    chk("c2.shadow3", 64'(shadow[127:96]), 64'h0);
    chk_ev("c2.ev", 2'd2, 5'd3, 32'hDEAD_BEEF);
    tick();
    chk_ev("c2.stall", 2'd2, 5'd3, 32'hDEAD_BEEF);
    ev_ready = 1'b1;
    tick();
    chk("c2.drained", 64'(ev_if.ev_valid), 64'd0);

    // core 3 event moves pointer back to 0
    set_wr(3, 5'd3, 32'h33, 1'b1);
    tick(); clr_tr();
    chk_ev("c3.ev", 2'd3, 5'd3, 32'h33);
    tick();
    chk("c3.drained", 64'(ev_if.ev_valid), 64'd0);

    // all cores at once: order 0,1,2,3
    for (int c = 0; c < 4; c++) set_wr(c, 5'd3, 32'(c + 1), 1'b1);
    tick(); clr_tr();
    for (int k = 0; k < 4; k++) begin
      chk_ev($sformatf("burst1.%0d", k), 2'(k), 5'd3, 32'(k + 1));
      tick();
    end
    chk("burst1.end", 64'(ev_if.ev_valid), 64'd0);
    chk("burst1.shadow", shadow, {32'd4, 32'd3, 32'd2, 32'd1});

    // cores 1,2 then all: next burst resumes at core 3
    set_wr(1, 5'd3, 32'h11, 1'b1);
    set_wr(2, 5'd3, 32'h22, 1'b1);
    tick(); clr_tr();
    chk_ev("burst2.0", 2'd1, 5'd3, 32'h11);
    tick();
    chk_ev("burst2.1", 2'd2, 5'd3, 32'h22);
    tick();
    chk("burst2.end", 64'(ev_if.ev_valid), 64'd0);
    for (int c = 0; c < 4; c++) set_wr(c, 5'd3, 32'hA0 + 32'(c), 1'b1);
    tick(); clr_tr();
    chk_ev("burst3.0", 2'd3, 5'd3, 32'hA3);
    tick();
    chk_ev("burst3.1", 2'd0, 5'd3, 32'hA0);
    tick();
    chk_ev("burst3.2", 2'd1, 5'd3, 32'hA1);
    tick();
    chk_ev("burst3.3", 2'd2, 5'd3, 32'hA2);
    tick();
    chk("burst3.end", 64'(ev_if.ev_valid), 64'd0);

    // overflow on core 0 with consumer stalled
    ev_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_wr(0, 5'd3, 32'h100 + 32'(k), 1'b1);
      tick();
    end
    clr_tr();
    chk("ovf.flag", 64'(ovf), 64'h1);
    chk("ovf.drop", 64'(drop_cnt), 64'd2);
    chk_ev("ovf.stable", 2'd0, 5'd3, 32'h100);
    chk("ovf.shadow0", 64'(shadow[31:0]), 64'h105);
    ev_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_ev($sformatf("ovf.drain%0d", k), 2'd0, 5'd3, 32'h100 + 32'(k));
    end
    tick();
    chk("ovf.end", 64'(ev_if.ev_valid), 64'd0);

    // r5, r0 and a non-writing trace beat
    set_wr(1, 5'd5, 32'h55, 1'b1);
    tick(); clr_tr();
    chk("r5.valid", 64'(ev_if.ev_valid), 64'd0);
    chk("r5.shadow1", 64'(shadow[63:32]), 64'hA1);
    chk("r5.m.valid", 64'(ev5_if.ev_valid), 64'd1);
    chk("r5.m.core", 64'(ev5_if.ev_core), 64'd1);
    chk("r5.m.reg", 64'(ev5_if.ev_reg), 64'd5);
    chk("r5.m.data", 64'(ev5_if.ev_data), 64'h55);
    tick();
    chk("r5.m.end", 64'(ev5_if.ev_valid), 64'd0);
    set_wr(1, 5'd0, 32'h77, 1'b1);
    set_wr(2, 5'd3, 32'h99, 1'b0);
    tick(); clr_tr();
    chk("r0.valid", 64'(ev_if.ev_valid), 64'd0);
    chk("r0.m.valid", 64'(ev5_if.ev_valid), 64'd0);
    chk("r0.shadow1", 64'(shadow[63:32]), 64'hA1);
    chk("nowe.shadow2", 64'(shadow[95:64]), 64'hA2);
    chk("r0.drop", 64'(drop_cnt), 64'd2);

    // fill cores 1,2; simultaneous drops coincide with ovf_clr
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_wr(1, 5'd3, 32'h200 + 32'(k), 1'b1);
      set_wr(2, 5'd3, 32'h300 + 32'(k), 1'b1);
      tick();
    end
    set_wr(1, 5'd3, 32'h2F0, 1'b1);
    set_wr(2, 5'd3, 32'h3F0, 1'b1);
    ovf_clr = 1'b1;
    tick(); clr_tr(); ovf_clr = 1'b0;
    chk("clr2.ovf", 64'(ovf), 64'h6);
    chk("clr2.drop", 64'(drop_cnt), 64'd2);
    set_wr(1, 5'd3, 32'h2F1, 1'b1);
    ovf_clr = 1'b1;
    tick(); clr_tr(); ovf_clr = 1'b0;
    chk("clr1.ovf", 64'(ovf), 64'h2);
    chk("clr1.drop", 64'(drop_cnt), 64'd1);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    chk("clr0.ovf", 64'(ovf), 64'h0);
    chk("clr0.drop", 64'(drop_cnt), 64'd0);
    chk_ev("clr.stable", 2'd1, 5'd3, 32'h200);

    // push and pop on full core-1 queue in the same cycle
    ev_ready = 1'b1;
    set_wr(1, 5'd3, 32'h2FF, 1'b1);
    tick(); clr_tr();
    chk_ev("pp.0", 2'd2, 5'd3, 32'h300);
    chk("pp.drop", 64'(drop_cnt), 64'd0);
    chk("pp.ovf", 64'(ovf), 64'h0);
    ec = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    ed = '{32'h201, 32'h301, 32'h202, 32'h302, 32'h203, 32'h303, 32'h2FF};
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_ev($sformatf("pp.%0d", k + 1), ec[k], 5'd3, ed[k]);
    end
    tick();
    chk("pp.end", 64'(ev_if.ev_valid), 64'd0);

    // reset with events queued
    ev_ready = 1'b0;
    set_wr(0, 5'd3, 32'h400, 1'b1);
    set_wr(1, 5'd3, 32'h401, 1'b1);
    set_wr(3, 5'd3, 32'h403, 1'b1);
    tick(); clr_tr();
    chk_ev("mid.ev", 2'd3, 5'd3, 32'h403);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.valid", 64'(ev_if.ev_valid), 64'd0);
    chk("mid.data", 64'(ev_if.ev_data), 64'd0);
    chk("mid.shadow_lo", shadow[63:0], 64'h0);
    chk("mid.shadow_hi", shadow[127:64], 64'h0);
    chk("mid.shadow5", shadow5[63:0], 64'h0);
    tick();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post.valid%0d", k), 64'(ev_if.ev_valid), 64'd0);
    end
    set_wr(1, 5'd3, 32'h500, 1'b1);
    tick(); clr_tr();
    chk_ev("post.ev", 2'd1, 5'd3, 32'h500);
    tick();
    chk("post.end", 64'(ev_if.ev_valid), 64'd0);
    chk("m.ovf", 64'(ovf5), 64'h0);
    chk("m.drop", 64'(drop5), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
